// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Desc     : Shared encodings for the MIPS EX stage (ALUOp, funct, FSM states)
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int c_wb_w    = 2;
    localparam int c_m_w     = 3;
    localparam int c_ex_w    = 4;
    localparam int c_funct_w = 6;
    localparam int c_reg_w   = 5;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [c_funct_w-1:0] c_funct_add = 6'b100000;
    localparam logic [c_funct_w-1:0] c_funct_sub = 6'b100010;
    localparam logic [c_funct_w-1:0] c_funct_and = 6'b100100;
    localparam logic [c_funct_w-1:0] c_funct_or  = 6'b100101;
    localparam logic [c_funct_w-1:0] c_funct_slt = 6'b101010;
    localparam logic [c_funct_w-1:0] c_funct_mul = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_latch.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_latch
// Desc     : EX/MEM pipeline register; a bubble loads all-zero contents
// Revision : 1.0
// ============================================================================
module ex_mem_latch
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bubble,
    input  logic [c_wb_w-1:0]  wb_d,
    input  logic [c_m_w-1:0]   m_d,
    input  logic [WIDTH-1:0]   add_d,
    input  logic               zero_d,
    input  logic [WIDTH-1:0]   alu_d,
    input  logic [WIDTH-1:0]   rdata2_d,
    input  logic [c_reg_w-1:0] dest_d,
    output logic [c_wb_w-1:0]  wb_q,
    output logic [c_m_w-1:0]   m_q,
    output logic [WIDTH-1:0]   add_q,
    output logic               zero_q,
    output logic [WIDTH-1:0]   alu_q,
    output logic [WIDTH-1:0]   rdata2_q,
    output logic [c_reg_w-1:0] dest_q
);

    logic [c_wb_w-1:0]  r_wb;
    logic [c_m_w-1:0]   r_m;
    logic [WIDTH-1:0]   r_add;
    logic               r_zero;
    logic [WIDTH-1:0]   r_alu;
    logic [WIDTH-1:0]   r_rdata2;
    logic [c_reg_w-1:0] r_dest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || bubble) begin
            r_wb     <= '0;
            r_m      <= '0;
            r_add    <= '0;
            r_zero   <= 1'b0;
            r_alu    <= '0;
            r_rdata2 <= '0;
            r_dest   <= '0;
        end else begin
            r_wb     <= wb_d;
            r_m      <= m_d;
            r_add    <= add_d;
            r_zero   <= zero_d;
            r_alu    <= alu_d;
            r_rdata2 <= rdata2_d;
            r_dest   <= dest_d;
        end
    end

    assign wb_q     = r_wb;
    assign m_q      = r_m;
    assign add_q    = r_add;
    assign zero_q   = r_zero;
    assign alu_q    = r_alu;
    assign rdata2_q = r_rdata2;
    assign dest_q   = r_dest;

endmodule
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// ============================================================================
// Module   : execute
// Desc     : MIPS EX stage: ALU, branch target, dest select, iterative mul
// Revision : 1.0
// ============================================================================
module execute
    import mips_pkg::*;
#(
    parameter int                    WIDTH     = 32,
    parameter logic [c_funct_w-1:0]  MUL_FUNCT = 6'b011000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [c_wb_w-1:0]  control_wb_in,
    input  logic [c_m_w-1:0]   control_m_in,
    input  logic [c_ex_w-1:0]  control_ex_in,
    input  logic [WIDTH-1:0]   npc,
    input  logic [WIDTH-1:0]   readdat1,
    input  logic [WIDTH-1:0]   readdat2,
    input  logic [WIDTH-1:0]   sign_ext,
    input  logic [c_reg_w-1:0] instr_2016,
    input  logic [c_reg_w-1:0] instr_1511,
    output logic               stall,
    output logic [c_wb_w-1:0]  ex_control_wb,
    output logic               Branch,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [WIDTH-1:0]   add_result,
    output logic               zero,
    output logic [WIDTH-1:0]   alu_result,
    output logic [WIDTH-1:0]   rdata2,
    output logic [c_reg_w-1:0] Write_reg
);

    localparam logic [4:0] c_last_step = 5'd31;

    logic [1:0]           w_alu_op;
    logic [c_funct_w-1:0] w_funct;
    logic [WIDTH-1:0]     w_alu_b;
    logic [c_reg_w-1:0]   w_dest;
    logic [WIDTH-1:0]     w_alu_result;
    logic [WIDTH-1:0]     w_ex_result;
    logic [WIDTH-1:0]     w_target;
    logic                 w_mul_req;

    ex_state_t            r_state;
    ex_state_t            w_state_next;
    logic                 w_stall_fsm;
    logic                 w_mul_load;
    logic                 w_mul_step;
    logic                 w_sel_acc;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [4:0]           r_count;
    logic [c_m_w-1:0]     w_m_q;

    assign w_alu_op  = control_ex_in[2:1];
    assign w_funct   = sign_ext[c_funct_w-1:0];
    assign w_alu_b   = control_ex_in[0] ? sign_ext : readdat2;
    assign w_dest    = control_ex_in[3] ? instr_1511 : instr_2016;
    assign w_target  = npc + (sign_ext << 2);
    assign w_mul_req = (w_alu_op == c_aluop_funct) && (w_funct == MUL_FUNCT);

    always_comb begin
        w_alu_result = '0;
        case (w_alu_op)
            c_aluop_add: w_alu_result = readdat1 + w_alu_b;
            c_aluop_sub: w_alu_result = readdat1 - w_alu_b;
            c_aluop_funct: begin
                case (w_funct)
                    c_funct_add: w_alu_result = readdat1 + w_alu_b;
                    c_funct_sub: w_alu_result = readdat1 - w_alu_b;
                    c_funct_and: w_alu_result = readdat1 & w_alu_b;
                    c_funct_or:  w_alu_result = readdat1 | w_alu_b;
                    c_funct_slt: w_alu_result = {{(WIDTH-1){1'b0}},
                                                 ($signed(readdat1) < $signed(w_alu_b))};
                    default:     w_alu_result = '0;
                endcase
            end
            default: w_alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_req) w_state_next = ST_RUN;
            ST_RUN:  if (r_count == c_last_step) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall_fsm = 1'b0;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        w_sel_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall_fsm = w_mul_req;
                w_mul_load  = w_mul_req;
            end
            ST_RUN: begin
                w_stall_fsm = 1'b1;
                w_mul_step  = 1'b1;
            end
            ST_DONE: w_sel_acc = 1'b1;
            default: ;
        endcase
    end

    // Front end must see no stall while reset holds, even with a mul parked in ID/EX
    assign stall = w_stall_fsm & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_mul_load) begin
            r_mcand  <= readdat1;
            r_mplier <= w_alu_b;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_mul_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 5'd1;
        end
    end

    assign w_ex_result = w_sel_acc ? r_acc : w_alu_result;

    ex_mem_latch #(
        .WIDTH (WIDTH)
    ) u_ex_mem_latch (
        .clk      (clk),
        .reset    (reset),
        .bubble   (w_stall_fsm),
        .wb_d     (control_wb_in),
        .m_d      (control_m_in),
        .add_d    (w_target),
        .zero_d   (w_ex_result == '0),
        .alu_d    (w_ex_result),
        .rdata2_d (readdat2),
        .dest_d   (w_dest),
        .wb_q     (ex_control_wb),
        .m_q      (w_m_q),
        .add_q    (add_result),
        .zero_q   (zero),
        .alu_q    (alu_result),
        .rdata2_q (rdata2),
        .dest_q   (Write_reg)
    );

    assign Branch   = w_m_q[2];
    assign MemRead  = w_m_q[1];
    assign MemWrite = w_m_q[0];

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute
// Desc     : Randomized self-checking bench for execute against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_execute;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic        br;
        logic        mr;
        logic        mw;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rdata2;
        logic [4:0]  wr;
    } out_t;

    logic        clk;
    logic        reset;
    logic [1:0]  control_wb_in;
    logic [2:0]  control_m_in;
    logic [3:0]  control_ex_in;
    logic [31:0] npc, readdat1, readdat2, sign_ext;
    logic [4:0]  instr_2016, instr_1511;
    logic        stall;
    logic [1:0]  ex_control_wb;
    logic        Branch, MemRead, MemWrite, zero;
    logic [31:0] add_result, alu_result, rdata2;
    logic [4:0]  Write_reg;

    int   n_checks = 0;
    int   n_errors = 0;
    out_t exp_out  = '0;
    out_t exp_next = '0;
    logic exp_stall = 1'b0;

    execute #(.WIDTH(32), .MUL_FUNCT(6'b011000)) dut (
        .clk(clk), .reset(reset),
        .control_wb_in(control_wb_in), .control_m_in(control_m_in), .control_ex_in(control_ex_in),
        .npc(npc), .readdat1(readdat1), .readdat2(readdat2), .sign_ext(sign_ext),
        .instr_2016(instr_2016), .instr_1511(instr_1511),
        .stall(stall), .ex_control_wb(ex_control_wb),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2(rdata2), .Write_reg(Write_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "stall",     32'(stall),         32'(exp_stall));
        chk(tag, "wb",        32'(ex_control_wb), 32'(exp_out.wb));
        chk(tag, "Branch",    32'(Branch),        32'(exp_out.br));
        chk(tag, "MemRead",   32'(MemRead),       32'(exp_out.mr));
        chk(tag, "MemWrite",  32'(MemWrite),      32'(exp_out.mw));
        chk(tag, "add_result", add_result,        exp_out.add);
        chk(tag, "zero",      32'(zero),          32'(exp_out.zero));
        chk(tag, "alu_result", alu_result,        exp_out.alu);
        chk(tag, "rdata2",    rdata2,             exp_out.rdata2);
        chk(tag, "Write_reg", 32'(Write_reg),     32'(exp_out.wr));
    endtask

    // Behavioural reference: what EX/MEM must hold after an instruction
    function automatic logic [31:0] operand_b(input in_t x);
        return x.ex[0] ? x.sext : x.r2;
    endfunction

    function automatic bit is_mul(input in_t x);
        return (x.ex[2:1] == 2'b10) && (x.sext[5:0] == 6'h18);
    endfunction

    function automatic out_t model_common(input in_t x, input logic [31:0] res);
        out_t o;
        o.wb     = x.wb;
        o.br     = x.m[2];
        o.mr     = x.m[1];
        o.mw     = x.m[0];
        o.add    = x.npc + x.sext * 32'd4;
        o.zero   = (res == 32'd0);
        o.alu    = res;
        o.rdata2 = x.r2;
        o.wr     = x.ex[3] ? x.rd : x.rt;
        return o;
    endfunction

    function automatic out_t model_alu(input in_t x);
        logic [31:0] a, b, r;
        a = x.r1;
        b = operand_b(x);
        r = 32'd0;
        if (x.ex[2:1] == 2'b00)      r = a + b;
        else if (x.ex[2:1] == 2'b01) r = a - b;
        else if (x.ex[2:1] == 2'b10) begin
            if      (x.sext[5:0] == 6'h20) r = a + b;
            else if (x.sext[5:0] == 6'h22) r = a - b;
            else if (x.sext[5:0] == 6'h24) r = a & b;
            else if (x.sext[5:0] == 6'h25) r = a | b;
            else if (x.sext[5:0] == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end
        return model_common(x, r);
    endfunction

    function automatic out_t model_mul(input in_t x);
        logic [31:0] p;
        p = x.r1 * operand_b(x);
        return model_common(x, p);
    endfunction

    task automatic drive_cycle(input in_t x, input logic rst_val, input logic st, input out_t nx);
        @(posedge clk);
        exp_out = exp_next;
        #1;
        reset         = rst_val;
        control_wb_in = x.wb;
        control_m_in  = x.m;
        control_ex_in = x.ex;
        npc           = x.npc;
        readdat1      = x.r1;
        readdat2      = x.r2;
        sign_ext      = x.sext;
        instr_2016    = x.rt;
        instr_1511    = x.rd;
        exp_stall     = st;
        exp_next      = nx;
    endtask

    // 33 stalled cycles each pushing a bubble, then the product on the 34th
    task automatic do_mul(input in_t x, input int abort_at);
        for (int i = 0; i < 34; i++) begin
            if (i == abort_at) return;
            drive_cycle(x, 1'b1, (i < 33), (i < 33) ? out_t'('0) : model_mul(x));
        end
    endtask

    task automatic run_instr(input in_t x);
        if (is_mul(x)) do_mul(x, -1);
        else           drive_cycle(x, 1'b1, 1'b0, model_alu(x));
    endtask

    function automatic in_t rand_instr();
        in_t x;
        logic [5:0] functs [6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        x.wb   = 2'($urandom_range(0, 3));
        x.m    = 3'($urandom_range(0, 7));
        x.ex   = 4'($urandom_range(0, 15));
        x.npc  = $urandom & 32'hFFFF_FFFC;
        x.r1   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
        x.r2   = ($urandom_range(0, 3) == 0) ? x.r1 : $urandom;
        x.sext = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
        if (x.ex[2:1] == 2'b10) begin
            functs[5] = 6'($urandom_range(0, 63));
            x.sext[5:0] = functs[$urandom_range(0, 5)];
        end
        x.rt   = 5'($urandom_range(0, 31));
        x.rd   = 5'($urandom_range(0, 31));
        return x;
    endfunction

    function automatic in_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                               input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
        in_t x;
        x.wb = wb; x.m = m; x.ex = ex; x.npc = pc; x.r1 = a; x.r2 = b;
        x.sext = imm; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            check_all("cycle");
        end
    end

    initial begin
        in_t nop, x;
        nop = '0;
        reset = 1'b1;
        control_wb_in = '0; control_m_in = '0; control_ex_in = '0;
        npc = '0; readdat1 = '0; readdat2 = '0; sign_ext = '0;
        instr_2016 = '0; instr_1511 = '0;
        #2 reset = 1'b0;
        #1 check_all("reset_async");
        drive_cycle(nop, 1'b0, 1'b0, '0);
        drive_cycle(nop, 1'b0, 1'b0, '0);

        // R-add 5 + 7 -> rd 3, released on the same cycle
        x = mk(2'b10, 3'b000, 4'b1100, 32'h100, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
        drive_cycle(x, 1'b1, 1'b0, model_alu(x));
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_add", "alu_result", alu_result, 32'd12);
        chk("lit_add", "Write_reg", 32'(Write_reg), 32'd3);
        chk("lit_add", "zero", 32'(zero), 32'd0);
        chk("lit_add", "wb", 32'(ex_control_wb), 32'd2);

        // beq 3-3, target 0x104 + 2*4
        x = mk(2'b00, 3'b100, 4'b0010, 32'h104, 32'd3, 32'd3, 32'd2, 5'd1, 5'd2);
        run_instr(x);
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_beq", "zero", 32'(zero), 32'd1);
        chk("lit_beq", "add_result", add_result, 32'h10C);
        chk("lit_beq", "Branch", 32'(Branch), 32'd1);

        x = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd0, 5'd4);
        run_instr(x);
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_slt", "alu_result", alu_result, 32'd1);
        x = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd0, 5'd4);
        run_instr(x);
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_slt_swap", "alu_result", alu_result, 32'd0);

        x = mk(2'b10, 3'b000, 4'b1100, 32'h200, 32'h0001_0003, 32'd5, 32'h18, 5'd0, 5'd8);
        run_instr(x);
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_mul", "alu_result", alu_result, 32'h0005_000F);
        chk("lit_mul", "RegWrite", 32'(ex_control_wb[1]), 32'd1);

        // Back-to-back multiplies
        x = mk(2'b10, 3'b000, 4'b1100, 32'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18, 5'd0, 5'd9);
        run_instr(x);
        run_instr(x);
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_mul_ff", "alu_result", alu_result, 32'd1);

        // Abort a multiply partway through RUN
        x = mk(2'b10, 3'b000, 4'b1100, 32'h400, 32'h1234_5678, 32'h9ABC_DEF1, 32'h18, 5'd0, 5'd10);
        do_mul(x, 11);
        #2 reset = 1'b0;
        exp_out = '0; exp_next = '0; exp_stall = 1'b0;
        #1 check_all("reset_mid_mul");
        drive_cycle(nop, 1'b0, 1'b0, '0);
        drive_cycle(nop, 1'b0, 1'b0, '0);
        x = mk(2'b10, 3'b000, 4'b1100, 32'h500, 32'd20, 32'd22, 32'h20, 5'd0, 5'd11);
        drive_cycle(x, 1'b1, 1'b0, model_alu(x));
        run_instr(nop);
        @(negedge clk); #1;
        chk("lit_post_reset", "alu_result", alu_result, 32'd42);

        for (int i = 0; i < 300; i++) begin
            run_instr(rand_instr());
            if (i % 75 == 0) begin
                x = rand_instr();
                x.ex[2:1] = 2'b10;
                x.sext[5:0] = 6'h18;
                run_instr(x);
            end
        end
        run_instr(nop);
        run_instr(nop);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute.md
# execute

EX stage of the 5-stage MIPS pipeline: consumes ID/EX latch contents, performs ALU/branch-target/destination selection, and registers results into the EX/MEM latch feeding the memory stage. Adds an iterative 32-cycle shift-add multiplier for R-type `mul` (low 32 bits of the product to rd). The multiplier stalls the front end via `stall` and inserts bubbles into EX/MEM while busy.

## Interface
Parameters:
- `WIDTH`, 32: datapath width.
- `MUL_FUNCT`, 6'b011000: funct code selecting the multiplier.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `control_wb_in` input 2: {RegWrite, MemtoReg} from ID/EX.
- `control_m_in` input 3: {Branch, MemRead, MemWrite} from ID/EX.
- `control_ex_in` input 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `npc` input 32: PC+4 of the instruction.
- `readdat1`, `readdat2` input 32: register operands.
- `sign_ext` input 32: sign-extended immediate; bits [5:0] carry funct.
- `instr_2016`, `instr_1511` input 5: rt / rd fields.
- `stall` output 1: hold PC, IF/ID and ID/EX this cycle.
- `ex_control_wb` output 2, `Branch`, `MemRead`, `MemWrite` output 1 each: registered controls to MEM.
- `add_result` output 32: registered branch target.
- `zero` output 1: registered ALU zero flag.
- `alu_result` output 32: registered ALU/mul result.
- `rdata2` output 32: registered store data (`readdat2`).
- `Write_reg` output 5: registered destination register.

## Operation
- ALU B = ALUSrc ? `sign_ext` : `readdat2`. Dest = RegDst ? `instr_1511` : `instr_2016`.
- ALUOp 00 → add; 01 → sub; 10 → funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1), `MUL_FUNCT` mul; any other funct/ALUOp 11 → result 0.
- add/sub wrap modulo 2^32, no overflow trap. `zero` = (result == 0).
- Branch target = `npc` + (`sign_ext` << 2), truncated to 32 bits.
- `mul_req` = ALUOp==10 && funct==`MUL_FUNCT`.
- FSM states:
  - IDLE: if `mul_req`, assert `stall`, capture multiplicand/multiplier/acc=0, count=0 → RUN. Otherwise pass through.
  - RUN: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. `stall`=1. When count==31 (32nd step done) → DONE.
  - DONE: `stall`=0; EX/MEM loads acc with the held ID/EX controls and dest → IDLE.
- While `stall`=1 EX/MEM loads a bubble: all control outputs 0, data outputs 0.
- Non-mul instructions never stall.

## Timing
- Single-cycle EX: result visible at EX/MEM outputs one edge after ID/EX presents it.
- mul: 1 (IDLE detect) + 32 (RUN) + 1 (DONE) = 34 cycles in EX; `stall` high 33 consecutive cycles; 33 bubbles reach MEM, then the product.
- `stall` is combinational from FSM state and `mul_req`. Upstream guarantees ID/EX is stable while `stall`=1.
- Back-to-back mul: DONE returns to IDLE; the next mul is detected in the following cycle. No overlap.
- Reset (any state, including mid-RUN): FSM → IDLE, counter/acc 0, `stall`=0, all EX/MEM outputs 0. The in-flight mul is discarded.
- Reset release: first valid latch on the first rising edge with `reset`=1.

## Structure
- Shared package `mips_pkg`: ALUOp encodings, funct constants (ADD/SUB/AND/OR/SLT/MUL), FSM state enum {IDLE, RUN, DONE}, control-bundle widths.
- Sub-module `ex_mem_latch`: EX/MEM register with bubble input, same clk/reset as parent. ALU, mux and FSM stay in `execute`.

## Test plan
- Reset: `reset`=0 during activity → all outputs 0, `stall`=0 immediately; hold through the release edge.
- R-add: 5 + 7, RegDst=1, rd=3 → next edge `alu_result`=12, `Write_reg`=3, `zero`=0, controls copied.
- beq: ALUOp=01, 3−3, `npc`=0x104, imm=2 → `zero`=1, `add_result`=0x10C, `Branch`=1.
- slt signed: 0xFFFFFFFF vs 1 → `alu_result`=1. Swapped operands → 0.
- mul: 0x00010003 × 5 → `stall` high exactly 33 cycles with bubbles in EX/MEM, then `alu_result`=0x0005000F and RegWrite=1. Repeat with 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- Reset mid-mul (cycle 10 of RUN) → `stall` drops, no product is ever emitted. A following add completes normally.
